ddr_traffic_tester: RTL and testbench

- Parametrised DDR traffic generator and checker; successor to the fixed 16-bit tester that drives the slow DDR3 controller's sysIO stream ports.
- Writes a selectable data pattern over a programmable address window, then reads the window back and compares each beat.
- Reports error count, first failing address/data, done/pass flags and iteration count.
- Replaces the UART-only result path; a separate reporter consumes the status outputs.

---
 rtl/ddr_traffic_tester.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_ddr_traffic_tester.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_traffic_tester.sv
// -----------------------------------------------------------------------------
// ddr_traffic_tester
// DDR traffic generator and checker. Writes a selectable data pattern over a
// programmable, inclusive address window, reads the window back and compares
// every beat. Optionally loops, inverting the data on odd passes.
//
// Ports
//   clk, rst        : controller clock, synchronous active-high reset
//   start, abort    : test start pulse (IDLE/DONE only), abort to IDLE
//   loop_en         : repeat write+read passes until abort
//   pattern_sel     : 0=address, 1=inverted address, 2=LFSR, 3=walking one
//   start_addr      : first beat address, latched on start
//   end_addr        : last beat address (inclusive), latched on start
//   init_fin        : controller initialisation complete
//   app_*           : controller stream request/response interface
//   busy/done/pass  : run status; pass is meaningful while done is high
//   cfg_err         : end_addr < start_addr at start
//   err_count       : saturating mismatch count
//   first_err_addr  : address of the first mismatch
//   first_err_data  : received data of the first mismatch
//   pass_count      : completed read passes (wraps)
// -----------------------------------------------------------------------------
module ddr_traffic_tester #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned ADDR_WIDTH     = 27,
   parameter int unsigned ERR_CNT_WIDTH  = 16,
   parameter int unsigned PASS_CNT_WIDTH = 16,
   parameter logic [31:0] LFSR_SEED      = 32'hACE1_2468
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      loop_en,
   input  logic [1:0]                pattern_sel,
   input  logic [ADDR_WIDTH-1:0]     start_addr,
   input  logic [ADDR_WIDTH-1:0]     end_addr,
   input  logic                      init_fin,
   output logic [ADDR_WIDTH-1:0]     app_addr,
   output logic                      app_wr_valid,
   input  logic                      app_wr_rdy,
   output logic [DATA_WIDTH-1:0]     app_wr_payload,
   output logic                      app_rd_rdy,
   input  logic                      app_rd_valid,
   input  logic [DATA_WIDTH-1:0]     app_rd_payload,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic                      cfg_err,
   output logic [ERR_CNT_WIDTH-1:0]  err_count,
   output logic [ADDR_WIDTH-1:0]     first_err_addr,
   output logic [DATA_WIDTH-1:0]     first_err_data,
   output logic [PASS_CNT_WIDTH-1:0] pass_count
);

   localparam int unsigned IDX_WIDTH = 5;
   localparam int unsigned ADDR_BITS = (ADDR_WIDTH < DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_INIT = 3'd1,
      ST_WRITE     = 3'd2,
      ST_READ      = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   // One step of the 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1.
   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      lfsr_step = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
   endfunction

   // Data for one beat; addr_data is the address already sized to the beat.
   function automatic logic [DATA_WIDTH-1:0] gen_pattern(
      input logic [1:0]            sel,
      input logic [DATA_WIDTH-1:0] addr_data,
      input logic [DATA_WIDTH-1:0] lfsr_data,
      input logic [IDX_WIDTH-1:0]  idx,
      input logic                  invert
   );
      logic [DATA_WIDTH-1:0] data;
      case (sel)
         2'd0:    data = addr_data;
         2'd1:    data = ~addr_data;
         2'd2:    data = lfsr_data;
         2'd3:    data = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << idx;
         default: data = addr_data;
      endcase
      gen_pattern = invert ? ~data : data;
   endfunction

   state_t                    state_r, state_s;
   logic [ADDR_WIDTH-1:0]     start_addr_r, start_addr_s;
   logic [ADDR_WIDTH-1:0]     end_addr_r, end_addr_s;
   logic [1:0]                sel_r, sel_s;
   logic [31:0]               lfsr_r, lfsr_s;
   logic [IDX_WIDTH-1:0]      idx_r, idx_s;
   logic [ADDR_WIDTH-1:0]     addr_r, addr_s;
   logic [DATA_WIDTH-1:0]     payload_r, payload_s;
   logic                      wr_valid_r, rd_rdy_r;
   logic                      busy_r, done_r, pass_r;
   logic                      cfg_err_r, cfg_err_s;
   logic [ERR_CNT_WIDTH-1:0]  err_count_r, err_count_s;
   logic [ADDR_WIDTH-1:0]     fe_addr_r, fe_addr_s;
   logic [DATA_WIDTH-1:0]     fe_data_r, fe_data_s;
   logic [PASS_CNT_WIDTH-1:0] pass_count_r, pass_count_s;

   logic                      wr_hs_s, rd_hs_s, mismatch_s;
   logic [DATA_WIDTH-1:0]     cur_addr_data_s, nxt_addr_data_s, expected_s;

   // Beat-sized views of the current and next address (zero-extended when narrow).
   always_comb begin
      cur_addr_data_s = {DATA_WIDTH{1'b0}};
      nxt_addr_data_s = {DATA_WIDTH{1'b0}};
      cur_addr_data_s[ADDR_BITS-1:0] = addr_r[ADDR_BITS-1:0];
      nxt_addr_data_s[ADDR_BITS-1:0] = addr_s[ADDR_BITS-1:0];
   end

   // Handshakes and read comparison for the beat currently at app_addr.
   always_comb begin
      wr_hs_s    = wr_valid_r & app_wr_rdy;
      rd_hs_s    = rd_rdy_r & app_rd_valid;
      expected_s = gen_pattern(sel_r, cur_addr_data_s, lfsr_r[DATA_WIDTH-1:0], idx_r,
                               pass_count_r[0]);
      mismatch_s = (app_rd_payload != expected_s);
   end

   // Next-state and datapath update; abort overrides everything else.
   always_comb begin
      state_s      = state_r;
      start_addr_s = start_addr_r;
      end_addr_s   = end_addr_r;
      sel_s        = sel_r;
      lfsr_s       = lfsr_r;
      idx_s        = idx_r;
      addr_s       = addr_r;
      cfg_err_s    = cfg_err_r;
      err_count_s  = err_count_r;
      fe_addr_s    = fe_addr_r;
      fe_data_s    = fe_data_r;
      pass_count_s = pass_count_r;

      if (abort) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  start_addr_s = start_addr;
                  end_addr_s   = end_addr;
                  sel_s        = pattern_sel;
                  lfsr_s       = LFSR_SEED;
                  idx_s        = {IDX_WIDTH{1'b0}};
                  addr_s       = start_addr;
                  err_count_s  = {ERR_CNT_WIDTH{1'b0}};
                  fe_addr_s    = {ADDR_WIDTH{1'b0}};
                  fe_data_s    = {DATA_WIDTH{1'b0}};
                  pass_count_s = {PASS_CNT_WIDTH{1'b0}};
                  if (end_addr < start_addr) begin
                     cfg_err_s = 1'b1;
                     state_s   = ST_DONE;
                  end else begin
                     cfg_err_s = 1'b0;
                     state_s   = ST_WAIT_INIT;
                  end
               end else begin
                  state_s = state_r;
               end
            end
            ST_WAIT_INIT: begin
               if (init_fin) begin
                  state_s = ST_WRITE;
               end else begin
                  state_s = ST_WAIT_INIT;
               end
            end
            ST_WRITE: begin
               if (wr_hs_s) begin
                  if (addr_r == end_addr_r) begin
                     // Read pass replays the pattern from the window start.
                     state_s = ST_READ;
                     addr_s  = start_addr_r;
                     lfsr_s  = LFSR_SEED;
                     idx_s   = {IDX_WIDTH{1'b0}};
                  end else begin
                     addr_s = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                     lfsr_s = lfsr_step(lfsr_r);
                     idx_s  = (idx_r == IDX_LAST) ? {IDX_WIDTH{1'b0}} : idx_r + 5'd1;
                  end
               end else begin
                  state_s = ST_WRITE;
               end
            end
            ST_READ: begin
               if (rd_hs_s) begin
                  if (mismatch_s) begin
                     if (err_count_r == {ERR_CNT_WIDTH{1'b0}}) begin
                        fe_addr_s = addr_r;
                        fe_data_s = app_rd_payload;
                     end else begin
                        fe_addr_s = fe_addr_r;
                     end
                     if (&err_count_r) begin
                        err_count_s = err_count_r;
                     end else begin
                        err_count_s = err_count_r + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
                     end
                  end else begin
                     err_count_s = err_count_r;
                  end
                  if (addr_r == end_addr_r) begin
                     pass_count_s = pass_count_r + {{(PASS_CNT_WIDTH-1){1'b0}}, 1'b1};
                     addr_s       = start_addr_r;
                     lfsr_s       = LFSR_SEED;
                     idx_s        = {IDX_WIDTH{1'b0}};
                     state_s      = loop_en ? ST_WRITE : ST_DONE;
                  end else begin
                     addr_s = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                     lfsr_s = lfsr_step(lfsr_r);
                     idx_s  = (idx_r == IDX_LAST) ? {IDX_WIDTH{1'b0}} : idx_r + 5'd1;
                  end
               end else begin
                  state_s = ST_READ;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // Write data is registered ahead so it is valid the cycle app_wr_valid rises.
   always_comb begin
      if (state_s == ST_WRITE) begin
         payload_s = gen_pattern(sel_s, nxt_addr_data_s, lfsr_s[DATA_WIDTH-1:0], idx_s,
                                 pass_count_s[0]);
      end else begin
         payload_s = payload_r;
      end
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         start_addr_r <= {ADDR_WIDTH{1'b0}};
         end_addr_r   <= {ADDR_WIDTH{1'b0}};
         sel_r        <= 2'd0;
         lfsr_r       <= LFSR_SEED;
         idx_r        <= {IDX_WIDTH{1'b0}};
         addr_r       <= {ADDR_WIDTH{1'b0}};
         payload_r    <= {DATA_WIDTH{1'b0}};
         wr_valid_r   <= 1'b0;
         rd_rdy_r     <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         pass_r       <= 1'b0;
         cfg_err_r    <= 1'b0;
         err_count_r  <= {ERR_CNT_WIDTH{1'b0}};
         fe_addr_r    <= {ADDR_WIDTH{1'b0}};
         fe_data_r    <= {DATA_WIDTH{1'b0}};
         pass_count_r <= {PASS_CNT_WIDTH{1'b0}};
      end else begin
         state_r      <= state_s;
         start_addr_r <= start_addr_s;
         end_addr_r   <= end_addr_s;
         sel_r        <= sel_s;
         lfsr_r       <= lfsr_s;
         idx_r        <= idx_s;
         addr_r       <= addr_s;
         payload_r    <= payload_s;
         wr_valid_r   <= (state_s == ST_WRITE);
         rd_rdy_r     <= (state_s == ST_READ);
         busy_r       <= (state_s == ST_WAIT_INIT) || (state_s == ST_WRITE) ||
                         (state_s == ST_READ);
         done_r       <= (state_s == ST_DONE);
         pass_r       <= (state_s == ST_DONE) && !cfg_err_s &&
                         (err_count_s == {ERR_CNT_WIDTH{1'b0}});
         cfg_err_r    <= cfg_err_s;
         err_count_r  <= err_count_s;
         fe_addr_r    <= fe_addr_s;
         fe_data_r    <= fe_data_s;
         pass_count_r <= pass_count_s;
      end
   end

   assign app_addr       = addr_r;
   assign app_wr_valid   = wr_valid_r;
   assign app_wr_payload = payload_r;
   assign app_rd_rdy     = rd_rdy_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign pass           = pass_r;
   assign cfg_err        = cfg_err_r;
   assign err_count      = err_count_r;
   assign first_err_addr = fe_addr_r;
   assign first_err_data = fe_data_r;
   assign pass_count     = pass_count_r;

endmodule

// File: tb/tb_ddr_traffic_tester.sv
// -----------------------------------------------------------------------------
// tb_ddr_traffic_tester
// Directed testbench for ddr_traffic_tester with default parameters
// (16-bit data, 27-bit address). A small memory model answers write and read
// requests; expected write data comes from an independent pattern model.
// -----------------------------------------------------------------------------
module tb_ddr_traffic_tester;

   logic        clk = 1'b0;
   logic        rst, start, abort, loop_en, init_fin;
   logic [1:0]  pattern_sel;
   logic [26:0] start_addr, end_addr;
   logic [26:0] app_addr;
   logic        app_wr_valid, app_wr_rdy, app_rd_rdy, app_rd_valid;
   logic [15:0] app_wr_payload, app_rd_payload;
   logic        busy, done, pass, cfg_err;
   logic [15:0] err_count, first_err_data, pass_count;
   logic [26:0] first_err_addr;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:255];
   logic [31:0] lfsr_ref [0:256];
   int cur_sel, cur_start, cur_end;

   always #5 clk = ~clk;

   ddr_traffic_tester dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
      .pattern_sel(pattern_sel), .start_addr(start_addr), .end_addr(end_addr),
      .init_fin(init_fin), .app_addr(app_addr), .app_wr_valid(app_wr_valid),
      .app_wr_rdy(app_wr_rdy), .app_wr_payload(app_wr_payload),
      .app_rd_rdy(app_rd_rdy), .app_rd_valid(app_rd_valid),
      .app_rd_payload(app_rd_payload), .busy(busy), .done(done), .pass(pass),
      .cfg_err(cfg_err), .err_count(err_count), .first_err_addr(first_err_addr),
      .first_err_data(first_err_data), .pass_count(pass_count)
   );

   // Reference data for beat 'beat' of pass 'pass_no'.
   function automatic logic [15:0] model_data(input int sel, input int addr,
                                              input int beat, input int pass_no);
      logic [31:0] a32;
      logic [15:0] d;
      a32 = addr;
      case (sel)
         0:       d = a32[15:0];
         1:       d = ~a32[15:0];
         2:       d = lfsr_ref[beat][15:0];
         default: d = 16'h0001 << (beat % 16);
      endcase
      if (pass_no % 2 == 1) d = ~d;
      return d;
   endfunction

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0; init_fin = 1'b1;
      pattern_sel = 2'd0; start_addr = 27'd0; end_addr = 27'd0;
      app_wr_rdy = 1'b0; app_rd_valid = 1'b0; app_rd_payload = 16'h0000;
      repeat (3) @(negedge clk);
   endtask

   // Pulse start for one cycle; returns at the first negedge after the start edge.
   task automatic do_start(input int sel, input int s, input int e);
      @(negedge clk);
      pattern_sel = sel[1:0]; start_addr = s[26:0]; end_addr = e[26:0];
      cur_sel = sel; cur_start = s; cur_end = e;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Memory model loop; checks write data and stall stability until done/abort.
   task automatic run_traffic(input bit stall, input bit corrupt, input int corrupt_addr,
                              input int abort_after, input int budget,
                              output int n_wr, output int n_rd);
      int bench_pass = 0;
      int cycles = 0;
      bit go = 1'b1;
      bit wr_stalled = 1'b0;
      bit rd_stalled = 1'b0;
      logic [26:0] prev_addr = 27'd0;
      logic [15:0] prev_data = 16'h0000;
      logic [15:0] exp;
      n_wr = 0; n_rd = 0;
      while (go) begin
         if (done) begin
            go = 1'b0;
         end else if (abort_after > 0 && bench_pass == abort_after) begin
            abort = 1'b1; app_wr_rdy = 1'b0; app_rd_valid = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            go = 1'b0;
         end else if (cycles >= budget) begin
            checks++; errors++;
            $display("FAIL traffic_timeout: cycles=%0d required done within %0d", cycles, budget);
            go = 1'b0;
         end else begin
            app_wr_rdy = 1'b0; app_rd_valid = 1'b0;
            if (app_wr_valid) begin
               if (wr_stalled) begin
                  checks++;
                  if (app_addr !== prev_addr || app_wr_payload !== prev_data) begin
                     errors++;
                     $display("FAIL wr_stable: addr=%h data=%h required addr=%h data=%h",
                              app_addr, app_wr_payload, prev_addr, prev_data);
                  end
               end
               if (!stall || $urandom_range(0, 3) != 0) begin
                  app_wr_rdy = 1'b1;
                  wr_stalled = 1'b0;
                  exp = model_data(cur_sel, int'(app_addr), int'(app_addr) - cur_start, bench_pass);
                  checks++;
                  if (app_wr_payload !== exp) begin
                     errors++;
                     $display("FAIL wr_data: addr=%h got=%h required=%h pass=%0d",
                              app_addr, app_wr_payload, exp, bench_pass);
                  end
                  mem[app_addr[7:0]] = app_wr_payload;
                  n_wr++;
               end else begin
                  wr_stalled = 1'b1; prev_addr = app_addr; prev_data = app_wr_payload;
               end
            end else begin
               wr_stalled = 1'b0;
            end
            if (app_rd_rdy) begin
               if (rd_stalled) begin
                  checks++;
                  if (app_addr !== prev_addr) begin
                     errors++;
                     $display("FAIL rd_stable: addr=%h required=%h", app_addr, prev_addr);
                  end
               end
               if (!stall || $urandom_range(0, 3) != 0) begin
                  app_rd_valid = 1'b1;
                  rd_stalled = 1'b0;
                  app_rd_payload = mem[app_addr[7:0]];
                  if (corrupt && int'(app_addr) == corrupt_addr)
                     app_rd_payload = app_rd_payload ^ 16'h0008;
                  n_rd++;
                  if (int'(app_addr) == cur_end) bench_pass++;
               end else begin
                  rd_stalled = 1'b1; prev_addr = app_addr;
               end
            end else begin
               rd_stalled = 1'b0;
            end
            @(negedge clk);
            cycles++;
         end
      end
      app_wr_rdy = 1'b0; app_rd_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({app_addr, app_wr_payload, app_wr_valid, app_rd_rdy} !== 45'd0) begin
         errors++;
         $display("FAIL reset_app: addr=%h data=%h valid=%b rdy=%b required all 0",
                  app_addr, app_wr_payload, app_wr_valid, app_rd_rdy);
      end
      checks++;
      if ({busy, done, pass, cfg_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: busy/done/pass/cfg_err=%b required 0000",
                  {busy, done, pass, cfg_err});
      end
      checks++;
      if ({err_count, first_err_addr, first_err_data, pass_count} !== 75'd0) begin
         errors++;
         $display("FAIL reset_status: err=%h fea=%h fed=%h pc=%h required 0",
                  err_count, first_err_addr, first_err_data, pass_count);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int n_wr, n_rd;
      do_start(0, 32'h10, 32'h13);
      checks++;
      if (app_wr_valid !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_wait: valid=%b busy=%b required 0 1", app_wr_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (app_wr_valid !== 1'b1 || app_wr_payload !== 16'h0010) begin
         errors++;
         $display("FAIL basic_first_write: valid=%b data=%h required 1 0010",
                  app_wr_valid, app_wr_payload);
      end
      run_traffic(1'b0, 1'b0, 0, 0, 100, n_wr, n_rd);
      checks++;
      if (n_wr != 4 || n_rd != 4) begin
         errors++;
         $display("FAIL basic_beats: writes=%0d reads=%0d required 4 4", n_wr, n_rd);
      end
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || err_count !== 16'd0 || pass_count !== 16'd1) begin
         errors++;
         $display("FAIL basic_status: done=%b pass=%b err=%0d pc=%0d required 1 1 0 1",
                  done, pass, err_count, pass_count);
      end
   endtask

   task automatic test_lfsr_stall();
      int n_wr, n_rd;
      do_start(2, 0, 255);
      run_traffic(1'b1, 1'b0, 0, 0, 3000, n_wr, n_rd);
      checks++;
      if (n_wr != 256 || n_rd != 256) begin
         errors++;
         $display("FAIL lfsr_beats: writes=%0d reads=%0d required 256 256", n_wr, n_rd);
      end
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || err_count !== 16'd0) begin
         errors++;
         $display("FAIL lfsr_status: done=%b pass=%b err=%0d required 1 1 0",
                  done, pass, err_count);
      end
   endtask

   task automatic test_corrupt();
      int n_wr, n_rd;
      do_start(3, 0, 15);
      run_traffic(1'b0, 1'b1, 5, 0, 200, n_wr, n_rd);
      checks++;
      if (err_count !== 16'd1) begin
         errors++;
         $display("FAIL corrupt_count: err=%0d required 1", err_count);
      end
      checks++;
      if (first_err_addr !== 27'h5 || first_err_data !== 16'h0028) begin
         errors++;
         $display("FAIL corrupt_first: addr=%h data=%h required 5 0028",
                  first_err_addr, first_err_data);
      end
      checks++;
      if (done !== 1'b1 || pass !== 1'b0) begin
         errors++;
         $display("FAIL corrupt_pass: done=%b pass=%b required 1 0", done, pass);
      end
   endtask

   task automatic test_cfg_err();
      bit traffic = 1'b0;
      do_start(0, 32'h20, 32'h1F);
      for (int i = 0; i < 6; i++) begin
         if (app_wr_valid || app_rd_rdy) traffic = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (traffic) begin
         errors++;
         $display("FAIL cfg_traffic: traffic=1 required 0");
      end
      checks++;
      if (cfg_err !== 1'b1 || done !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL cfg_status: cfg_err=%b done=%b pass=%b busy=%b required 1 1 0 0",
                  cfg_err, done, pass, busy);
      end
   endtask

   task automatic test_loop_abort();
      int n_wr, n_rd;
      loop_en = 1'b1;
      do_start(0, 0, 7);
      run_traffic(1'b0, 1'b0, 0, 3, 500, n_wr, n_rd);
      loop_en = 1'b0;
      checks++;
      if (n_wr != 24 || n_rd != 24) begin
         errors++;
         $display("FAIL loop_beats: writes=%0d reads=%0d required 24 24", n_wr, n_rd);
      end
      checks++;
      if (app_wr_valid !== 1'b0 || app_rd_rdy !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: valid=%b rdy=%b busy=%b done=%b required 0 0 0 0",
                  app_wr_valid, app_rd_rdy, busy, done);
      end
      checks++;
      if (pass_count !== 16'd3 || err_count !== 16'd0) begin
         errors++;
         $display("FAIL abort_status: pc=%0d err=%0d required 3 0", pass_count, err_count);
      end
   endtask

   task automatic test_init_wait_reset();
      bit early = 1'b0;
      bit seen = 1'b0;
      init_fin = 1'b0;
      do_start(0, 0, 3);
      for (int i = 0; i < 100; i++) begin
         if (app_wr_valid || app_rd_rdy || !busy) early = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL init_hold: traffic_or_idle=1 required 0");
      end
      init_fin = 1'b1;
      for (int i = 0; i < 5 && !seen; i++) begin
         @(negedge clk);
         if (app_wr_valid) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL init_release: valid=0 required 1 within 5 cycles");
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({app_addr, app_wr_payload, app_wr_valid, app_rd_rdy, busy, done, pass, cfg_err}
          !== 49'd0) begin
         errors++;
         $display("FAIL midwrite_reset: addr=%h data=%h valid=%b busy=%b required all 0",
                  app_addr, app_wr_payload, app_wr_valid, busy);
      end
      rst = 1'b0;
   endtask

   initial begin
      lfsr_ref[0] = 32'hACE1_2468;
      for (int i = 0; i < 256; i++)
         lfsr_ref[i+1] = {lfsr_ref[i][30:0],
                          lfsr_ref[i][31] ^ lfsr_ref[i][21] ^ lfsr_ref[i][1] ^ lfsr_ref[i][0]};
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      test_reset();
      test_basic();
      test_lfsr_stall();
      test_corrupt();
      test_cfg_err();
      test_loop_abort();
      test_init_wait_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
